// File: rtl/alu_multicycle.sv
// Integer ALU for the EX stage: single-cycle logic/arith/compare/shift ops plus
// radix-2 iterative RV32M multiply/divide/remainder behind a valid/ready handshake.
module alu_multicycle #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     DivZero
);

    localparam int unsigned W   = DATA_WIDTH;
    localparam int unsigned W2  = 2 * DATA_WIDTH;
    localparam int unsigned SHW = $clog2(DATA_WIDTH);

    localparam logic [OPCODE_LENGTH-1:0] OP_AND   = OPCODE_LENGTH'('h00);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR    = OPCODE_LENGTH'('h01);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD   = OPCODE_LENGTH'('h02);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLTU  = OPCODE_LENGTH'('h03);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR   = OPCODE_LENGTH'('h05);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB   = OPCODE_LENGTH'('h06);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT   = OPCODE_LENGTH'('h07);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ    = OPCODE_LENGTH'('h08);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL   = OPCODE_LENGTH'('h09);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL   = OPCODE_LENGTH'('h0A);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA   = OPCODE_LENGTH'('h0B);
    localparam logic [OPCODE_LENGTH-1:0] OP_MUL   = OPCODE_LENGTH'('h10);
    localparam logic [OPCODE_LENGTH-1:0] OP_MULH  = OPCODE_LENGTH'('h11);
    localparam logic [OPCODE_LENGTH-1:0] OP_MULHU = OPCODE_LENGTH'('h12);
    localparam logic [OPCODE_LENGTH-1:0] OP_DIV   = OPCODE_LENGTH'('h13);
    localparam logic [OPCODE_LENGTH-1:0] OP_DIVU  = OPCODE_LENGTH'('h14);
    localparam logic [OPCODE_LENGTH-1:0] OP_REM   = OPCODE_LENGTH'('h15);
    localparam logic [OPCODE_LENGTH-1:0] OP_REMU  = OPCODE_LENGTH'('h16);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                   state_q, state_d;
    logic [W-1:0]             hi_q, hi_d, lo_q, lo_d, m_q, m_d;
    logic [SHW-1:0]           cnt_q, cnt_d;
    logic [OPCODE_LENGTH-1:0] op_q, op_d;
    logic                     neg_q, neg_d;
    logic [W-1:0]             result_d;
    logic                     dz_d;

    logic [SHW-1:0] shamt;
    logic [W-1:0]   alu_c, fast_c, a_mag, b_mag, final_c;
    logic           is_mul, is_div, is_rem, sa, sb, neg_c, b_zero, ovf;
    logic [W:0]     sum, sh;
    logic [W-1:0]   diff, mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;
    logic           ge;
    logic [W2-1:0]  prod;

    assign shamt = SrcB[SHW-1:0];

    // Single-cycle result straight from the inputs
    always_comb begin
        alu_c = '0;
        case (Operation)
            OP_AND:  alu_c = SrcA & SrcB;
            OP_OR:   alu_c = SrcA | SrcB;
            OP_ADD:  alu_c = SrcA + SrcB;
            OP_XOR:  alu_c = SrcA ^ SrcB;
            OP_SUB:  alu_c = SrcA - SrcB;
            OP_SLT:  alu_c = W'($signed(SrcA) < $signed(SrcB));
            OP_SLTU: alu_c = W'(SrcA < SrcB);
            OP_EQ:   alu_c = W'(SrcA == SrcB);
            OP_SLL:  alu_c = SrcA << shamt;
            OP_SRL:  alu_c = SrcA >> shamt;
            OP_SRA:  alu_c = W'($unsigned($signed(SrcA) >>> shamt));
            default: alu_c = '0;
        endcase
    end

    // Operand classification, magnitudes and divide fast-path results
    always_comb begin
        is_mul = (Operation == OP_MUL) || (Operation == OP_MULH) || (Operation == OP_MULHU);
        is_div = (Operation == OP_DIV) || (Operation == OP_DIVU);
        is_rem = (Operation == OP_REM) || (Operation == OP_REMU);
        sa     = ((Operation == OP_MULH) || (Operation == OP_DIV) || (Operation == OP_REM)) && SrcA[W-1];
        sb     = ((Operation == OP_MULH) || (Operation == OP_DIV) || (Operation == OP_REM)) && SrcB[W-1];
        neg_c  = (Operation == OP_REM) ? sa : (sa ^ sb);
        a_mag  = sa ? (~SrcA + W'(1)) : SrcA;
        b_mag  = sb ? (~SrcB + W'(1)) : SrcB;
        b_zero = (SrcB == '0);
        ovf    = ((Operation == OP_DIV) || (Operation == OP_REM)) &&
                 (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
        fast_c = '0;
        if (b_zero)   fast_c = is_div ? '1 : SrcA;
        else if (ovf) fast_c = (Operation == OP_DIV) ? SrcA : '0;
    end

    // One shift-add (multiply) or restoring-subtract (divide) step
    always_comb begin
        sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        mul_hi_n = sum[W:1];
        mul_lo_n = {sum[0], lo_q[W-1:1]};
        sh       = {hi_q, lo_q[W-1]};
        ge       = (sh >= {1'b0, m_q});
        diff     = W'(sh - {1'b0, m_q});
        div_hi_n = ge ? diff : sh[W-1:0];
        div_lo_n = {lo_q[W-2:0], ge};
        prod     = {mul_hi_n, mul_lo_n};
        final_c  = '0;
        case (op_q)
            OP_MUL:   final_c = prod[W-1:0];
            OP_MULH:  final_c = neg_q ? W'((~prod + W2'(1)) >> W) : prod[W2-1:W];
            OP_MULHU: final_c = prod[W2-1:W];
            OP_DIV, OP_DIVU: final_c = neg_q ? (~div_lo_n + W'(1)) : div_lo_n;
            OP_REM, OP_REMU: final_c = neg_q ? (~div_hi_n + W'(1)) : div_hi_n;
            default:  final_c = '0;
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = ALUResult;
        dz_d     = DivZero;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d = Operation;
                    if (is_mul || ((is_div || is_rem) && !b_zero && !ovf)) begin
                        state_d = CALC;
                        hi_d    = '0;
                        cnt_d   = '0;
                        neg_d   = neg_c;
                        lo_d    = is_mul ? b_mag : a_mag;
                        m_d     = is_mul ? a_mag : b_mag;
                    end else begin
                        state_d  = DONE;
                        result_d = (is_div || is_rem) ? fast_c : alu_c;
                        dz_d     = (is_div || is_rem) && b_zero;
                    end
                end
            end
            CALC: begin
                hi_d  = (op_q == OP_MUL || op_q == OP_MULH || op_q == OP_MULHU) ? mul_hi_n : div_hi_n;
                lo_d  = (op_q == OP_MUL || op_q == OP_MULH || op_q == OP_MULHU) ? mul_lo_n : div_lo_n;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(W - 1)) begin
                    state_d  = DONE;
                    result_d = final_c;
                    dz_d     = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            ALUResult <= '0;
            DivZero   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            ALUResult <= result_d;
            DivZero   <= dz_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: a 32-bit and a 16-bit instance sharing operand buses.
`timescale 1ns/1ps
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid32, in_valid16, out_ready;
    logic [31:0] SrcA, SrcB;
    logic [4:0]  Operation;
    logic        in_ready32, out_valid32, dz32;
    logic [31:0] res32;
    logic        in_ready16, out_valid16, dz16;
    logic [15:0] res16;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.DATA_WIDTH(32), .OPCODE_LENGTH(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .out_valid(out_valid32),
        .out_ready(out_ready), .ALUResult(res32), .DivZero(dz32)
    );

    alu_multicycle #(.DATA_WIDTH(16), .OPCODE_LENGTH(5)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .SrcA(SrcA[15:0]), .SrcB(SrcB[15:0]), .Operation(Operation), .out_valid(out_valid16),
        .out_ready(out_ready), .ALUResult(res16), .DivZero(dz16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one op to the chosen instance, wait for the result, check it, then consume it
    task automatic run_op(input bit w16, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit exp_dz,
                          input int exp_lat, input string tag);
        int lat;
        @(negedge clk);
        SrcA = a; SrcB = b; Operation = op;
        in_valid32 = !w16; in_valid16 = w16;
        @(posedge clk); #1;
        in_valid32 = 1'b0; in_valid16 = 1'b0;
        SrcA = ~a; SrcB = ~b; Operation = 5'h02;
        lat = 1;
        while (!(w16 ? out_valid16 : out_valid32) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, w16 ? {16'h0, res16} : res32, exp);
        check({tag, "_dz"}, 32'(w16 ? dz16 : dz32), 32'(exp_dz));
        check({tag, "_rdy"}, 32'(w16 ? in_ready16 : in_ready32), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_ovlo"}, 32'(w16 ? out_valid16 : out_valid32), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid32 = 1'b0; in_valid16 = 1'b0; out_ready = 1'b0;
        SrcA = '0; SrcB = '0; Operation = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", 32'(in_ready32), 32'd1);
        check("rst_ov", 32'(out_valid32), 32'd0);
        check("rst_res", res32, 32'd0);
        check("rst_dz", 32'(dz32), 32'd0);
        check("rst_rdy16", 32'(in_ready16), 32'd1);
        @(negedge clk); rst_n = 1'b1;

        // ADD with output hold while out_ready stays low
        @(negedge clk);
        SrcA = 32'h7FFF_FFFF; SrcB = 32'h1; Operation = 5'h02; in_valid32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0; SrcA = 32'h0; SrcB = 32'h0;
        check("add_ov", 32'(out_valid32), 32'd1);
        check("add_res", res32, 32'h8000_0000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("hold_ov", 32'(out_valid32), 32'd1);
            check("hold_res", res32, 32'h8000_0000);
            check("hold_rdy", 32'(in_ready32), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("rel_ov", 32'(out_valid32), 32'd0);
        check("rel_rdy", 32'(in_ready32), 32'd1);
        check("rel_res", res32, 32'h8000_0000);

        // Single-cycle ops
        run_op(0, 5'h07, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 1, "slt");
        run_op(0, 5'h03, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 1, "sltu");
        run_op(0, 5'h0B, 32'h8000_0000, 32'h24, 32'hF800_0000, 0, 1, "sra");
        run_op(0, 5'h0A, 32'h8000_0000, 32'h24, 32'h0800_0000, 0, 1, "srl");
        run_op(0, 5'h09, 32'h0000_0003, 32'h3F, 32'h8000_0000, 0, 1, "sll");
        run_op(0, 5'h00, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 0, 1, "and");
        run_op(0, 5'h01, 32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11, 0, 1, "or");
        run_op(0, 5'h05, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 0, 1, "xor");
        run_op(0, 5'h06, 32'h0000_0000, 32'h1, 32'hFFFF_FFFF, 0, 1, "sub");
        run_op(0, 5'h08, 32'h1234_5678, 32'h1234_5678, 32'h1, 0, 1, "eq");
        run_op(0, 5'h1F, 32'h1234_5678, 32'h1, 32'h0, 0, 1, "badop");

        // Iterative ops, 32-bit
        run_op(0, 5'h10, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFEB, 0, 33, "mul");
        run_op(0, 5'h11, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 0, 33, "mulh");
        run_op(0, 5'h12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 33, "mulhu");
        run_op(0, 5'h13, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 0, 33, "div");
        run_op(0, 5'h15, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 0, 33, "rem");
        run_op(0, 5'h14, 32'd100, 32'd7, 32'd14, 0, 33, "divu");
        run_op(0, 5'h16, 32'd100, 32'd7, 32'd2, 0, 33, "remu");

        // Divide fast paths
        run_op(0, 5'h14, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1, "divu0");
        run_op(0, 5'h16, 32'd5, 32'd0, 32'd5, 1, 1, "remu0");
        run_op(0, 5'h13, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1, "divovf");
        run_op(0, 5'h15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, 1, "removf");

        // Reset in the middle of a divide
        run_op(0, 5'h16, 32'd100, 32'd7, 32'd2, 0, 33, "pre_rst");
        @(negedge clk);
        SrcA = 32'hFFFF_FFF9; SrcB = 32'h2; Operation = 5'h13; in_valid32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        check("mrst_ov", 32'(out_valid32), 32'd0);
        check("mrst_res", res32, 32'd0);
        check("mrst_rdy", 32'(in_ready32), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("mrst_quiet", 32'(out_valid32), 32'd0);
        run_op(0, 5'h02, 32'd2, 32'd3, 32'd5, 0, 1, "add_after");

        // Iterative ops and fast paths, 16-bit
        run_op(1, 5'h10, 32'hFFFD, 32'h7, 32'hFFEB, 0, 17, "mul16");
        run_op(1, 5'h11, 32'hFFFD, 32'h7, 32'hFFFF, 0, 17, "mulh16");
        run_op(1, 5'h12, 32'hFFFF, 32'hFFFF, 32'hFFFE, 0, 17, "mulhu16");
        run_op(1, 5'h13, 32'hFFF9, 32'h2, 32'hFFFD, 0, 17, "div16");
        run_op(1, 5'h15, 32'hFFF9, 32'h2, 32'hFFFF, 0, 17, "rem16");
        run_op(1, 5'h14, 32'd100, 32'd7, 32'd14, 0, 17, "divu16");
        run_op(1, 5'h16, 32'd100, 32'd7, 32'd2, 0, 17, "remu16");
        run_op(1, 5'h14, 32'd5, 32'd0, 32'hFFFF, 1, 1, "divu016");
        run_op(1, 5'h13, 32'h8000, 32'hFFFF, 32'h8000, 0, 1, "divovf16");
        run_op(1, 5'h15, 32'h8000, 32'hFFFF, 32'h0, 0, 1, "removf16");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
Parametrised successor to the single-cycle integer ALU in the RISC-V datapath. Adds signed/unsigned compares, shifts, and RV32M multiply/divide/remainder; mul/div are computed iteratively (radix-2, one bit per cycle). Sits in the EX stage behind a valid/ready handshake so the pipeline stalls while a long operation is in flight. The result is registered and held until the consumer accepts it.

Parameters:
DATA_WIDTH, 32, operand/result width; power of 2, at least 8.
OPCODE_LENGTH, 5, width of Operation.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst_n  in  1  synchronous active-low reset.
in_valid  in  1  operands and Operation are valid this cycle.
in_ready  out  1  block can accept an operation; high only in IDLE.
SrcA  in  DATA_WIDTH  operand A (rs1).
SrcB  in  DATA_WIDTH  operand B (rs2/imm).
Operation  in  OPCODE_LENGTH  operation select.
out_valid  out  1  ALUResult/DivZero valid; high only in DONE.
out_ready  in  1  consumer accepts the result.
ALUResult  out  DATA_WIDTH  registered result.
DivZero  out  1  registered; 1 when the completed op was DIV/DIVU/REM/REMU with SrcB==0.

Behaviour:
- Reset (rst_n==0 at clk edge): state=IDLE; in_ready=1; out_valid=0; ALUResult=0; DivZero=0; iteration counter and internal registers cleared. Reset mid-CALC or mid-DONE discards the operation with no output.
- Accept: in_valid & in_ready at edge N latches SrcA, SrcB and Operation. Input changes after acceptance have no effect.
- States: IDLE -> DONE (single-cycle op, or fast-pathed div) | IDLE -> CALC (MUL*/DIV*/REM*); CALC -> DONE after DATA_WIDTH iterations; DONE -> IDLE when out_ready.
- Latency: single-cycle ops out_valid at N+1; iterative ops out_valid at N+1+DATA_WIDTH (CALC lasts exactly DATA_WIDTH cycles). No overlap: in_ready=0 in CALC and DONE.
- Out hold: in DONE, ALUResult/DivZero/out_valid are stable until out_ready is high at an edge. That edge returns to IDLE with out_valid=0 and ALUResult holding its last value. A new op can be accepted the following cycle. out_ready is ignored outside DONE.
- Encodings (hex), single-cycle:
  - 00 AND, 01 OR, 02 ADD, 05 XOR, 06 SUB (all wrap modulo 2^DATA_WIDTH).
  - 07 SLT signed, 03 SLTU unsigned; 1 if A<B else 0, zero-extended.
  - 08 EQ: 1 if A==B.
  - 09 SLL, 0A SRL, 0B SRA; shift amount = SrcB[log2(DATA_WIDTH)-1:0], upper bits ignored.
- Encodings (hex), iterative:
  - 10 MUL: low half of product.
  - 11 MULH: high half, signed x signed.
  - 12 MULHU: high half, unsigned x unsigned.
  - 13 DIV signed, 14 DIVU; quotient rounds toward zero.
  - 15 REM signed (sign of dividend), 16 REMU.
- Any other encoding: ALUResult=0, single-cycle.
- Signed mul/div: operate on magnitudes; negate the result per operand signs in the final CALC cycle.
- Fast path, single-cycle latency, no CALC:
  - Divisor 0: DIV/DIVU -> all ones; REM/REMU -> SrcA; DivZero=1.
  - Signed overflow (A = most-negative, B = -1): DIV -> most-negative; REM -> 0; DivZero=0.
- DivZero=0 for all non-divide ops.

Test Plan:
- Reset then ADD A=0x7FFFFFFF, B=1: in_valid one cycle -> out_valid next cycle, ALUResult=0x80000000; out_ready=0 for 3 cycles -> result held and in_ready=0; out_ready=1 -> IDLE, in_ready=1.
- SLT A=0xFFFFFFFF, B=1 -> 1; SLTU same operands -> 0; SRA A=0x80000000, B=0x24 -> 0xF8000000.
- MUL A=0xFFFFFFFD (-3), B=7 -> 0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF; MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE. Each: out_valid exactly 33 cycles after accept.
- DIV A=-7 (0xFFFFFFF9), B=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU A=100, B=7 -> 14, REMU -> 2; latency 33.
- DIVU A=5, B=0 -> 0xFFFFFFFF with DivZero=1, latency 1. DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000 with DivZero=0, latency 1. REM same operands -> 0.
- Start DIV, drive rst_n=0 at CALC cycle 10 -> next cycle out_valid=0, ALUResult=0, in_ready=1. A following ADD 2+3 -> 5 with latency 1. Repeat all mul/div checks with DATA_WIDTH=16 (latency 17).
